// File: rtl/retire_map_tx.sv
// Retire stage and architectural map table.
// Up to WAYS instructions retire each cycle, oldest first. The committed map
// is updated, each previous mapping (told) is passed to the freelist, and the
// stage pulses a recovery request after a mispredicted branch retires. It
// stops accepting input after a halt retires.
module retire_map_tx #(
    parameter int WAYS   = 2,
    parameter int N_ARCH = 32,
    parameter int N_PHYS = 64,
    localparam int AW    = $clog2(N_ARCH),
    localparam int PW    = $clog2(N_PHYS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WAYS-1:0]              rob_valid_i,
    input  logic [WAYS-1:0]              rob_dest_valid_i,
    input  logic [WAYS-1:0][AW-1:0]      rob_arch_dest_i,
    input  logic [WAYS-1:0][PW-1:0]      rob_t_idx_i,
    input  logic [WAYS-1:0]              rob_mispredict_i,
    input  logic [WAYS-1:0]              rob_halt_i,
    output logic [WAYS-1:0]              ret_valid_o,
    output logic [WAYS-1:0][PW-1:0]      ret_told_idx_o,
    output logic                         br_recover_enable_o,
    output logic [N_ARCH-1:0][PW-1:0]    recovery_map_o,
    output logic [63:0]                  retired_count_o,
    output logic                         halted_o
);

    logic [N_ARCH-1:0][PW-1:0] arch_map_q, arch_map_d;
    logic [WAYS-1:0]           ret_valid_q, ret_valid_d;
    logic [WAYS-1:0][PW-1:0]   told_q, told_d;
    logic                      br_q, br_d;
    logic                      halted_q, halted_d;
    logic [63:0]               count_q, count_d;
    logic [63:0]               count_inc;
    logic                      ignore_inputs;
    logic                      cut_seen;

    // Inputs are dead during the ROB flush cycle and after a halt.
    assign ignore_inputs = br_q | halted_q;

    // Walk the slots oldest first: accept until a mispredict/halt cut (inclusive),
    // reading told from the map as already updated by older slots this cycle.
    always_comb begin
        arch_map_d  = arch_map_q;
        ret_valid_d = '0;
        told_d      = '0;
        br_d        = 1'b0;
        halted_d    = halted_q;
        count_inc   = 64'd0;
        cut_seen    = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!ignore_inputs && rob_valid_i[i] && !cut_seen) begin
                count_inc = count_inc + 64'd1;
                if (rob_dest_valid_i[i]) begin
                    ret_valid_d[i]                  = 1'b1;
                    told_d[i]                       = arch_map_d[rob_arch_dest_i[i]];
                    arch_map_d[rob_arch_dest_i[i]]  = rob_t_idx_i[i];
                end
                if (rob_mispredict_i[i]) begin
                    br_d = 1'b1;
                end
                if (rob_halt_i[i]) begin
                    halted_d = 1'b1;
                end
                if (rob_mispredict_i[i] || rob_halt_i[i]) begin
                    cut_seen = 1'b1;
                end
            end
        end
        count_d = count_q + count_inc;
    end

    // Commit map updates and register every output; reset wins over retire.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < N_ARCH; a++) begin
                arch_map_q[a] <= PW'(a);
            end
            ret_valid_q <= '0;
            told_q      <= '0;
            br_q        <= 1'b0;
            halted_q    <= 1'b0;
            count_q     <= 64'd0;
        end else begin
            arch_map_q  <= arch_map_d;
            ret_valid_q <= ret_valid_d;
            told_q      <= told_d;
            br_q        <= br_d;
            halted_q    <= halted_d;
            count_q     <= count_d;
        end
    end

    assign ret_valid_o         = ret_valid_q;
    assign ret_told_idx_o      = told_q;
    assign br_recover_enable_o = br_q;
    assign recovery_map_o      = arch_map_q;
    assign retired_count_o     = count_q;
    assign halted_o            = halted_q;

endmodule
